// File: rtl/ast_arb_pkg.sv
// Shared types, default widths and the round-robin pick helper for the Avalon-ST
// packet arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   rr_pick     : first set request scanning ptr, ptr+1, ... modulo n
package ast_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int unsigned DEF_DATA_WIDTH    = 64;
  localparam int unsigned DEF_CHANNEL_WIDTH = 10;
  localparam int unsigned DEF_TX_DIR        = 4;

  // Upper bound on the number of requesters rr_pick can scan.
  localparam int unsigned MAX_TX_DIR = 32;

  // Returns the index of the first request found starting at ptr and wrapping at n.
  // Returns 0 when no request is set; callers qualify with |req.
  function automatic int unsigned rr_pick(input logic [MAX_TX_DIR-1:0] req,
                                          input int unsigned           ptr,
                                          input int unsigned           n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_TX_DIR; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[4:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ast_packet_arbiter_rr.sv
// Combinational round-robin arbiter.
//   req    : one request bit per requester
//   ptr    : highest-priority requester this round
//   winner : index of the granted requester (valid only when found)
//   found  : at least one request is set
module rr_arbiter
  import ast_arb_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned SEL_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] winner,
  output logic                 found
);

  logic [MAX_TX_DIR-1:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    winner         = SEL_WIDTH'(rr_pick(req_ext, 32'(ptr), N));
    found          = |req;
  end

endmodule

// File: rtl/ast_packet_arbiter.sv
// N-to-1 Avalon-ST packet arbiter. Grants one sink per packet in round-robin order
// and holds the grant from startofpacket to endofpacket, so packets never interleave.
// Ports:
//   clk, srst               : clock, asynchronous active-high reset
//   ast_*_i (per input k)   : sink streams, input k in slice k; ast_ready_o per input
//   ast_*_o, ast_ready_i    : merged source stream
//   ast_dir_o               : index of the granted input, stable for the whole packet
//   proto_err_o             : one-cycle pulse after a headless beat was dropped
module ast_packet_arbiter
  import ast_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
  parameter int unsigned CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
  parameter int unsigned TX_DIR        = DEF_TX_DIR,
  parameter int unsigned DIR_SEL_WIDTH = $clog2(TX_DIR)
) (
  input  logic                              clk,
  input  logic                              srst,
  input  logic [TX_DIR*DATA_WIDTH-1:0]      ast_data_i,
  input  logic [TX_DIR-1:0]                 ast_startofpacket_i,
  input  logic [TX_DIR-1:0]                 ast_endofpacket_i,
  input  logic [TX_DIR-1:0]                 ast_valid_i,
  input  logic [TX_DIR*EMPTY_WIDTH-1:0]     ast_empty_i,
  input  logic [TX_DIR*CHANNEL_WIDTH-1:0]   ast_channel_i,
  output logic [TX_DIR-1:0]                 ast_ready_o,
  output logic [DATA_WIDTH-1:0]             ast_data_o,
  output logic                              ast_startofpacket_o,
  output logic                              ast_endofpacket_o,
  output logic                              ast_valid_o,
  output logic [EMPTY_WIDTH-1:0]            ast_empty_o,
  output logic [CHANNEL_WIDTH-1:0]          ast_channel_o,
  input  logic                              ast_ready_i,
  output logic [DIR_SEL_WIDTH-1:0]          ast_dir_o,
  output logic                              proto_err_o
);

  arb_state_t               state_q, state_d;
  logic [DIR_SEL_WIDTH-1:0] grant_q, grant_d;
  logic [DIR_SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                     proto_err_q, proto_err_d;

  logic [TX_DIR-1:0]        req;
  logic [TX_DIR-1:0]        headless;
  logic [DIR_SEL_WIDTH-1:0] winner;
  logic                     found;
  logic                     busy;
  logic                     eop_xfer;

  assign req      = ast_valid_i & ast_startofpacket_i;
  assign headless = ast_valid_i & ~ast_startofpacket_i;
  assign busy     = (state_q == BUSY);

  rr_arbiter #(
    .N         (TX_DIR),
    .SEL_WIDTH (DIR_SEL_WIDTH)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .found  (found)
  );

  // Source side is always a mux of the granted input; valid is qualified by BUSY.
  always_comb begin
    ast_data_o          = ast_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
    ast_empty_o         = ast_empty_i[grant_q*EMPTY_WIDTH +: EMPTY_WIDTH];
    ast_channel_o       = ast_channel_i[grant_q*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    ast_startofpacket_o = ast_startofpacket_i[grant_q];
    ast_endofpacket_o   = ast_endofpacket_i[grant_q];
    ast_valid_o         = busy & ast_valid_i[grant_q];
    ast_dir_o           = grant_q;
    proto_err_o         = proto_err_q;
    eop_xfer            = busy & ast_valid_i[grant_q] & ast_ready_i & ast_endofpacket_i[grant_q];
  end

  // In IDLE every headless beat is accepted so it gets dropped instead of blocking
  // the input forever. Held at zero while reset is asserted.
  always_comb begin
    ast_ready_o = '0;
    if (!srst) begin
      if (busy) begin
        ast_ready_o[grant_q] = ast_ready_i;
      end else begin
        ast_ready_o = headless;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    proto_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        proto_err_d = |headless;
        if (found) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (eop_xfer) begin
          // The input just served becomes lowest priority.
          rr_ptr_d = (grant_q == DIR_SEL_WIDTH'(TX_DIR - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: doc/ast_packet_arbiter.md
Name: ast_packet_arbiter

Overview:
- N-to-1 Avalon-ST packet arbiter, the counterpart of the demux: merges TX_DIR sink streams onto one source stream.
- Round-robin grant, locked for a whole packet (startofpacket to endofpacket), so packets are never interleaved.
- Reports the granted input index on ast_dir_o, so downstream logic can re-route or tag each packet.
- Sits between per-direction producers and a shared downstream consumer.

Parameters:
- DATA_WIDTH, 64, data bus width in bits (multiple of 8).
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8), width of the empty field.
- CHANNEL_WIDTH, 10, width of the channel field.
- TX_DIR, 4, number of sink (input) ports, >= 2.
- DIR_SEL_WIDTH, $clog2(TX_DIR), width of the grant index.

Ports:
- clk  in  1  clock
- srst  in  1  reset, asynchronous, active-high
- ast_data_i  in  TX_DIR*DATA_WIDTH  sink data, input k in slice k
- ast_startofpacket_i  in  TX_DIR  per-input sop
- ast_endofpacket_i  in  TX_DIR  per-input eop
- ast_valid_i  in  TX_DIR  per-input valid
- ast_empty_i  in  TX_DIR*EMPTY_WIDTH  per-input empty
- ast_channel_i  in  TX_DIR*CHANNEL_WIDTH  per-input channel
- ast_ready_o  out  TX_DIR  per-input ready
- ast_data_o  out  DATA_WIDTH  source data
- ast_startofpacket_o  out  1  source sop
- ast_endofpacket_o  out  1  source eop
- ast_valid_o  out  1  source valid
- ast_empty_o  out  EMPTY_WIDTH  source empty
- ast_channel_o  out  CHANNEL_WIDTH  source channel
- ast_ready_i  in  1  source ready
- ast_dir_o  out  DIR_SEL_WIDTH  index of the granted input; stable for the whole packet
- proto_err_o  out  1  one-cycle pulse when a headless beat is dropped

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, rr_ptr=0, proto_err_o=0.
  - All ast_ready_o=0, ast_valid_o=0, ast_dir_o=0.
- Transfer rule: a beat on input k transfers when ast_valid_i[k] && ast_ready_o[k].
- FSM, two states:
  - IDLE:
    - Request on k = ast_valid_i[k] && ast_startofpacket_i[k].
    - Winner = first requester scanning rr_ptr, rr_ptr+1, ... mod TX_DIR.
    - On a winner: register grant=winner, go to BUSY next cycle.
    - No beat is transferred in IDLE, so arbitration costs 1 bubble cycle per packet.
  - IDLE headless beats:
    - Any input with valid && !sop gets ast_ready_o[k]=1, and its beat is dropped.
    - proto_err_o pulses the cycle after the drop (registered).
    - Several drops in one cycle produce a single pulse.
  - BUSY:
    - Source outputs are a combinational mux of input grant.
    - ast_ready_o[grant]=ast_ready_i; all other ast_ready_o=0.
    - ast_dir_o=grant.
    - When a beat with eop transfers: rr_ptr=grant+1 (wrap at TX_DIR-1 to 0), go to IDLE.
  - Single-beat packets (sop && eop) complete in one BUSY cycle.
- Outside BUSY: ast_valid_o=0. Source data, empty and channel are don't-care but driven from input grant.
- Backpressure: ast_ready_i=0 in BUSY stalls the granted input; the FSM holds state.
- A granted input dropping valid mid-packet leaves BUSY held; no timeout.
- A second sop on the granted input before eop is passed through unchanged. The arbiter does not police it.
- ast_dir_o changes only on the IDLE->BUSY transition.
- srst asserted mid-packet aborts it immediately; the partial packet is not completed.
- Fairness: after a packet from k, input k has lowest priority. With all inputs requesting, grant order is 0,1,2,...,TX_DIR-1,0.

Decomposition:
- Package ast_arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - localparam defaults for the widths;
  - function rr_pick(req, ptr), returning the round-robin winner index.
- Sub-module rr_arbiter (TX_DIR requests, rr_ptr, winner index and found flag) is natural and reusable. Mux and FSM stay in the top.

Test Plan:
- Single input: input 2 sends a 3-beat packet with ast_ready_i=1.
  - Output valid starts 1 cycle after sop is presented.
  - 3 beats out, data and empty identical to input; ast_dir_o=2 throughout.
- Contention: all 4 inputs hold 2-beat packets from reset.
  - Output packet order is 0,1,2,3.
  - Each packet is contiguous; exactly 1 idle cycle between packets.
- Backpressure: ast_ready_i toggles 1,0,1,0 during a 4-beat packet on input 1.
  - ast_ready_o[1] mirrors ast_ready_i; ast_ready_o of all other inputs stays 0.
  - No beat is lost or duplicated.
- Headless beat: input 3 shows valid=1, sop=0 in IDLE.
  - ast_ready_o[3]=1 in that cycle, proto_err_o=1 the next cycle.
  - Nothing appears on the output.
- Reset mid-packet: srst pulses during beat 2 of 5 on input 0.
  - ast_valid_o=0 and all ast_ready_o=0 immediately.
  - After release, a new packet from input 1 is granted with ast_dir_o=1.
- Single-beat packets: sop=eop=1 back-to-back on inputs 0 and 1.
  - Outputs alternate 0,1, each packet 1 beat followed by 1 bubble.
